// File: rtl/et_peak_collector.sv
// et_peak_collector
// Collects peak-flagged ET samples during a trigger window, tags each one with
// its position in the window, and buffers {ts, et} in a show-ahead FIFO that
// drains over a valid/ready interface. Also reports a per-window peak count,
// a sticky overflow flag and a one-cycle window-done pulse.
module et_peak_collector #(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned TS_W  = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [16:0]          in_et,
    input  logic                 win_start,
    input  logic [TS_W-1:0]      win_len,
    output logic                 win_busy,
    output logic                 win_done,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [TS_W+15:0]     out_data,
    output logic [3:0]           n_peak,
    output logic                 overflow
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = AW + 1;
    localparam int unsigned DW = TS_W + 16;

    typedef enum logic {
        IDLE = 1'b0,
        OPEN = 1'b1
    } state_t;

    state_t            state_q;
    state_t            state_d;

    logic [TS_W-1:0]   ts_q;
    logic [TS_W-1:0]   len_q;
    logic [3:0]        n_peak_q;
    logic              overflow_q;
    logic              win_done_q;

    logic [DW-1:0]     mem [DEPTH];
    logic [AW-1:0]     wr_ptr_q;
    logic [AW-1:0]     rd_ptr_q;
    logic [CW-1:0]     count_q;

    logic              open_win;
    logic              closing;
    logic              flagged;
    logic              push;
    logic              drop;
    logic              pop;
    logic              full;
    logic              not_empty;

    assign not_empty = (count_q != '0);
    assign full      = (count_q == CW'(DEPTH));

    // Next-state logic and per-edge window/FIFO control decisions.
    always_comb begin
        state_d  = state_q;
        open_win = 1'b0;
        closing  = 1'b0;
        flagged  = 1'b0;
        push     = 1'b0;
        drop     = 1'b0;
        pop      = not_empty && out_ready;
        case (state_q)
            IDLE: begin
                if (win_start) begin
                    state_d  = OPEN;
                    open_win = 1'b1;
                end
            end
            OPEN: begin
                flagged = in_et[16];
                // Fullness is judged before the edge, so a simultaneous pop
                // does not make room for this sample.
                push    = flagged && !full;
                drop    = flagged && full;
                if (ts_q == (len_q - TS_W'(1))) begin
                    state_d = IDLE;
                    closing = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Window state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Timestamp, latched length, peak count, overflow and done pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ts_q       <= '0;
            len_q      <= '0;
            n_peak_q   <= '0;
            overflow_q <= 1'b0;
            win_done_q <= 1'b0;
        end else begin
            win_done_q <= closing;
            if (open_win) begin
                len_q      <= win_len;
                ts_q       <= '0;
                n_peak_q   <= '0;
                overflow_q <= 1'b0;
            end else if (state_q == OPEN) begin
                ts_q <= ts_q + TS_W'(1);
                if (flagged && (n_peak_q != 4'd15)) begin
                    n_peak_q <= n_peak_q + 4'd1;
                end
                if (drop) begin
                    overflow_q <= 1'b1;
                end
            end
        end
    end

    // FIFO storage, pointers and occupancy count.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr_q] <= {ts_q, in_et[15:0]};
                wr_ptr_q      <= wr_ptr_q + AW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    assign win_busy  = (state_q == OPEN);
    assign win_done  = win_done_q;
    assign out_valid = not_empty;
    assign out_data  = mem[rd_ptr_q];
    assign n_peak    = n_peak_q;
    assign overflow  = overflow_q;

endmodule

// File: tb/tb_et_peak_collector.sv
// Directed self-checking bench for et_peak_collector (DEPTH=8, TS_W=8).
module tb_et_peak_collector;

    logic        clk;
    logic        rst;
    logic [16:0] in_et;
    logic        win_start;
    logic [7:0]  win_len;
    logic        win_busy;
    logic        win_done;
    logic        out_valid;
    logic        out_ready;
    logic [23:0] out_data;
    logic [3:0]  n_peak;
    logic        overflow;

    int checks   = 0;
    int failures = 0;

    et_peak_collector #(.DEPTH(8), .TS_W(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_et     (in_et),
        .win_start (win_start),
        .win_len   (win_len),
        .win_busy  (win_busy),
        .win_done  (win_done),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .n_peak    (n_peak),
        .overflow  (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic basic_capture(input string pfx);
        logic [16:0] vec [4];
        logic        ev  [4];
        logic [23:0] ed  [4];
        vec[0] = 17'h00010; vec[1] = 17'h10123; vec[2] = 17'h00005; vec[3] = 17'h10456;
        ev[0]  = 1'b0;      ev[1]  = 1'b1;      ev[2]  = 1'b0;      ev[3]  = 1'b1;
        ed[0]  = 24'h0;     ed[1]  = 24'h010123; ed[2] = 24'h0;     ed[3]  = 24'h030456;
        out_ready = 1'b1;
        in_et     = '0;
        win_len   = 8'd4;
        win_start = 1'b1;
        step();
        win_start = 1'b0;
        check({pfx, "_busy_open"}, win_busy, 1);
        check({pfx, "_npeak_clr"}, n_peak, 0);
        for (int i = 0; i < 4; i++) begin
            in_et = vec[i];
            step();
            check($sformatf("%s_valid_%0d", pfx, i), out_valid, ev[i]);
            if (ev[i]) check($sformatf("%s_data_%0d", pfx, i), out_data, ed[i]);
            check($sformatf("%s_done_%0d", pfx, i), win_done, (i == 3));
            check($sformatf("%s_busy_%0d", pfx, i), win_busy, (i < 3));
        end
        check({pfx, "_npeak"}, n_peak, 2);
        check({pfx, "_ovf"}, overflow, 0);
        in_et = '0;
        step();
        check({pfx, "_done_end"}, win_done, 0);
        check({pfx, "_valid_end"}, out_valid, 0);
    endtask

    initial begin
        logic [23:0] exp_q [$];
        logic [23:0] prev_data;
        logic [23:0] first_d;
        logic [23:0] last_d;
        logic        prev_stall;
        logic [9:0]  mask;
        int          popped;
        int          cnt;

        rst = 1'b1; in_et = '0; win_start = 1'b0; win_len = '0; out_ready = 1'b0;
        #3;
        check("rst_valid", out_valid, 0);
        check("rst_data", out_data, 0);
        check("rst_busy", win_busy, 0);
        check("rst_done", win_done, 0);
        check("rst_npeak", n_peak, 0);
        check("rst_ovf", overflow, 0);
        step(); step();
        rst = 1'b0;
        step();

        // Basic capture
        basic_capture("bc");

        // Overflow: 12 flagged samples into an 8-deep FIFO with no draining
        out_ready = 1'b0;
        win_len   = 8'd12;
        win_start = 1'b1;
        step();
        win_start = 1'b0;
        for (int i = 0; i < 12; i++) begin
            in_et = {1'b1, 16'hA000 + 16'(i)};
            step();
            if (i == 7) check("ov_ovf_at8", overflow, 0);
            if (i == 8) check("ov_ovf_at9", overflow, 1);
        end
        in_et = '0;
        check("ov_done", win_done, 1);
        check("ov_npeak", n_peak, 12);
        check("ov_ovf", overflow, 1);
        out_ready = 1'b1;
        for (int e = 0; e < 8; e++) begin
            check($sformatf("ov_valid_%0d", e), out_valid, 1);
            check($sformatf("ov_data_%0d", e), out_data, {8'(e), 16'hA000 + 16'(e)});
            step();
        end
        check("ov_empty", out_valid, 0);

        // Backpressure: 6 peaks in a 10-sample window, random ready
        mask       = 10'b1010101101;
        popped     = 0;
        prev_stall = 1'b0;
        prev_data  = '0;
        out_ready  = 1'b0;
        win_len    = 8'd10;
        win_start  = 1'b1;
        step();
        win_start = 1'b0;
        for (int c = 0; c < 80; c++) begin
            if (c < 10 && mask[c]) in_et = {1'b1, 16'hB000 + 16'(c)};
            else in_et = '0;
            out_ready = 1'($urandom_range(0, 1));
            if (prev_stall) begin
                check("bp_hold_valid", out_valid, 1);
                check("bp_hold_data", out_data, prev_data);
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    check("bp_spurious", out_valid, 0);
                end else begin
                    check($sformatf("bp_pop_%0d", popped), out_data, exp_q.pop_front());
                end
                popped++;
            end
            if (c < 10 && mask[c]) exp_q.push_back({8'(c), 16'hB000 + 16'(c)});
            prev_stall = out_valid && !out_ready;
            prev_data  = out_data;
            step();
            if (c >= 10 && popped >= 6) break;
        end
        check("bp_popped", popped, 6);
        in_et = '0;
        out_ready = 1'b0;

        // Mid-window win_start must not move the close cycle
        win_len   = 8'd6;
        win_start = 1'b1;
        step();
        for (int i = 1; i <= 6; i++) begin
            win_start = (i == 3);
            win_len   = (i == 3) ? 8'd3 : 8'd6;
            step();
            check($sformatf("mid_busy_%0d", i), win_busy, (i < 6));
            check($sformatf("mid_done_%0d", i), win_done, (i == 6));
        end
        win_start = 1'b0;

        // win_len=0 gives 256 busy cycles; every sample flagged, draining
        out_ready = 1'b1;
        in_et     = 17'h1CAFE;
        win_len   = 8'd0;
        win_start = 1'b1;
        step();
        win_start = 1'b0;
        cnt = 0;
        while (win_busy && cnt < 300) begin
            cnt++;
            step();
        end
        check("len0_cycles", cnt, 256);
        check("len0_done", win_done, 1);
        check("len0_npeak_sat", n_peak, 15);
        check("len0_ovf", overflow, 0);

        // Back-to-back open on the done cycle; flagged input at the opening edge ignored
        win_len   = 8'd2;
        win_start = 1'b1;
        step();
        win_start = 1'b0;
        check("b2b_busy", win_busy, 1);
        check("b2b_npeak_clr", n_peak, 0);
        check("b2b_done", win_done, 0);
        step(); step();
        check("b2b_npeak", n_peak, 2);
        check("b2b_close", win_done, 1);
        in_et = '0;
        step(); step();
        check("b2b_empty", out_valid, 0);

        // Saturation with 20 flagged samples, FIFO left full
        out_ready = 1'b0;
        win_len   = 8'd20;
        win_start = 1'b1;
        step();
        win_start = 1'b0;
        for (int i = 0; i < 20; i++) begin
            in_et = {1'b1, 16'hC000 + 16'(i)};
            step();
        end
        check("sat_npeak", n_peak, 15);
        check("sat_ovf", overflow, 1);
        in_et = '0;

        // Full FIFO: push and pop on the same edge drops the push
        win_len   = 8'd1;
        win_start = 1'b1;
        step();
        win_start = 1'b0;
        in_et     = 17'h1D000;
        out_ready = 1'b1;
        step();
        in_et = '0;
        check("fp_ovf", overflow, 1);
        check("fp_npeak", n_peak, 1);
        check("fp_done", win_done, 1);
        cnt = 0;
        first_d = out_data;
        last_d  = '0;
        while (out_valid && cnt < 20) begin
            last_d = out_data;
            cnt++;
            step();
        end
        check("fp_count", cnt, 7);
        check("fp_first", first_d, 24'h01C001);
        check("fp_last", last_d, 24'h07C007);

        // Reset mid-window with 3 buffered entries and ts=5
        out_ready = 1'b0;
        win_len   = 8'd10;
        win_start = 1'b1;
        step();
        win_start = 1'b0;
        for (int i = 0; i < 5; i++) begin
            in_et = (i < 3) ? {1'b1, 16'hE000 + 16'(i)} : 17'h0;
            step();
        end
        in_et = '0;
        check("rm_pre_valid", out_valid, 1);
        check("rm_pre_npeak", n_peak, 3);
        #2;
        rst = 1'b1;
        #1;
        check("rm_valid", out_valid, 0);
        check("rm_busy", win_busy, 0);
        check("rm_npeak", n_peak, 0);
        step();
        check("rm_done_held", win_done, 0);
        rst = 1'b0;
        step();
        check("rm_done_after", win_done, 0);
        check("rm_valid_after", out_valid, 0);
        basic_capture("rb");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        failures++;
        $display("FAIL timeout observed=running expected=finished");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "timeout");
    end

endmodule

// File: doc/et_peak_collector.md
# et_peak_collector

Consumer of the 17-bit peak-tagged ET stream `{is_peak, et[15:0]}` produced by the ET peak-sensing stage. During a trigger window opened by `win_start`, the block timestamps every flagged sample and buffers `{timestamp, et}` in a small show-ahead FIFO. The FIFO is drained over a valid/ready interface toward the CDT readout. It also reports a per-window peak count, a sticky overflow flag and a window-done pulse.

## Interface
- `DEPTH`, 8: FIFO entries; power of two, 2..64.
- `TS_W`, 8: timestamp width. It is also the width of `win_len`.
- `clk` in 1: system clock; all logic on the rising edge.
- `rst` in 1: reset, asynchronous and active-high.
- `in_et` in 17: bit 16 = peak flag; bits 15:0 = ET of that peak.
- `win_start` in 1: single-cycle request to open a window.
- `win_len` in TS_W: window length in cycles. 0 means 2^TS_W. Sampled when the window opens.
- `win_busy` out 1: high while the window is open.
- `win_done` out 1: one-cycle pulse on the edge where the window closes.
- `out_valid` out 1: FIFO non-empty.
- `out_ready` in 1: downstream accepts the head entry.
- `out_data` out TS_W+16: head entry `{ts, et}`.
- `n_peak` out 4: flagged samples seen in the current or last window. Saturates at 15.
- `overflow` out 1: sticky; at least one flagged sample was dropped in the current or last window.

## Operation
- States: IDLE, OPEN.
- IDLE → OPEN when an edge samples `win_start`=1.
  - On that edge: latch `win_len` into `len_q`; clear `ts`, `n_peak` and `overflow`.
  - FIFO contents are kept.
- `win_start` in OPEN is ignored. It does not extend or restart the window.
- On each edge in OPEN:
  - If `in_et[16]`=1, increment `n_peak` (saturating at 15).
  - If additionally the FIFO is not full, push `{ts, in_et[15:0]}`.
  - If the FIFO is full, drop the sample and set `overflow`=1.
  - `ts` increments, wrapping at 2^TS_W.
  - When `ts` == `len_q`-1 (mod 2^TS_W): go to IDLE and pulse `win_done` for the following cycle.
- Window length:
  - Exactly `len_q` samples are inspected.
  - They carry ts = 0..`len_q`-1.
  - With `len_q`=0, 2^TS_W samples are inspected.
- In IDLE, `in_et` is ignored entirely.
- FIFO:
  - Show-ahead: `out_valid` = (count≠0); `out_data` = head entry.
  - Pop on an edge with `out_valid`&&`out_ready`.
  - Popping is independent of window state.
- Fullness:
  - "Full" is count==DEPTH evaluated before the edge.
  - A push with a simultaneous pop while full is still dropped; count becomes DEPTH-1.
  - A push with a simultaneous pop while not full leaves count unchanged.
- `out_data` must stay stable while `out_valid`=1 and `out_ready`=0.
- Pointers wrap modulo DEPTH. Count is DEPTH+1 states wide (0..DEPTH).
- Reset values:
  - state IDLE; `win_busy` 0; `win_done` 0.
  - `out_valid` 0; `out_data` 0; `n_peak` 0; `overflow` 0.
  - `ts` 0; FIFO pointers and count 0.
- Reset mid-window aborts the window. Buffered entries are discarded. `win_done` is not pulsed.

## Timing
- `win_start` sampled at edge k:
  - `win_busy`=1 from cycle k+1.
  - The first inspected sample (ts=0) is `in_et` at edge k+1.
- The last sample is at edge k+`len_q`. `win_busy`=0 and `win_done`=1 in the cycle after it.
- A new `win_start` is accepted at the edge where `win_done` is high (back-to-back windows).
- Push latency: a flagged sample at edge j makes `out_valid`=1 in cycle j+1 when the FIFO was empty.
- No combinational path from `in_et` or `win_start` to any output.
- `out_valid` does not depend combinationally on `out_ready`.
- `n_peak` and `overflow` are registered and update on the same edge as the push.

## Test plan
- Basic capture: `win_len`=4, `out_ready`=1, `in_et` = 0x0_0010, 0x1_0123, 0x0_0005, 0x1_0456.
  - `out_data` = 0x01_0123, then 0x03_0456.
  - `n_peak`=2, `overflow`=0.
  - `win_done` pulses exactly 5 cycles after the `win_start` edge.
- Overflow: DEPTH=8, `out_ready`=0, `win_len`=12, all samples flagged.
  - FIFO holds ts 0..7.
  - `overflow`=1, `n_peak`=12.
  - Draining afterwards yields exactly 8 entries in order.
- Backpressure: random `out_ready` (50%), 6 peaks in a 10-cycle window.
  - All 6 entries emerge in ts order.
  - `out_data` is unchanged during every valid&&!ready cycle.
- Window control:
  - `win_start` pulsed again mid-window does not change the close cycle.
  - `win_len`=0 gives `win_busy` high for exactly 256 cycles.
  - A back-to-back `win_start` on the `win_done` cycle opens a new window with `n_peak` cleared.
- Saturation and full-with-pop: 20 flagged samples give `n_peak`=15. With the FIFO full and pop&&push on the same edge, the push is dropped and count=7.
- Reset mid-window: assert `rst` with 3 buffered entries and `ts`=5.
  - `out_valid`, `win_busy` and `n_peak` drop to 0 without waiting for a clock edge.
  - No `win_done` pulse.
  - The next `win_start` after release behaves as in the basic-capture test.
